// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB first, even parity, one stop bit.
// Each bit is sampled once, at its midpoint, from a two-flop synchronised copy
// of the line. A finished frame comes out as a one-cycle valid strobe, with
// parity and framing error flags that stay valid until the next strobe.
module uart_rx #(
   parameter int BR       = 9600,
   parameter int CLK_RATE = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RX_serial_in_bit,
   output logic [7:0] RX_data_out,
   output logic       RX_data_valid,
   output logic       RX_parity_error,
   output logic       RX_framing_error,
   output logic       RX_active
);

   localparam int POSEDGES_FOR_BIT = CLK_RATE / BR;
   localparam int HALF_BIT         = POSEDGES_FOR_BIT / 2;
   localparam int CNT_NEED         = $clog2(POSEDGES_FOR_BIT);
   localparam int CNT_W            = (CNT_NEED > 16) ? CNT_NEED : 16;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(POSEDGES_FOR_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rx_s;
   logic [CNT_W-1:0] counter;
   logic [2:0]       bit_index;
   logic [7:0]       shift;
   logic             par_bit;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_serial_in_bit;
         rx_s    <= rx_meta;
      end
   end

   // Frame state machine: finds the start bit, then samples each later bit at its midpoint.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         counter          <= '0;
         bit_index        <= '0;
         shift            <= '0;
         par_bit          <= 1'b0;
         RX_data_out      <= '0;
         RX_data_valid    <= 1'b0;
         RX_parity_error  <= 1'b0;
         RX_framing_error <= 1'b0;
         RX_active        <= 1'b0;
      end else begin
         RX_data_valid <= 1'b0;
         case (state)
            IDLE: begin
               counter   <= '0;
               RX_active <= 1'b0;
               if (!rx_s) begin
                  state     <= START;
                  RX_active <= 1'b1;
                  counter   <= CNT_W'(1);
               end
            end
            START: begin
               if (counter == HALF_LAST) begin
                  counter <= '0;
                  if (rx_s) begin
                     state     <= IDLE;
                     RX_active <= 1'b0;
                  end else begin
                     bit_index <= '0;
                     state     <= DATA;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DATA: begin
               if (counter == BIT_LAST) begin
                  counter           <= '0;
                  shift[bit_index]  <= rx_s;
                  if (bit_index == 3'd7) begin
                     state <= PARITY;
                  end else begin
                     bit_index <= bit_index + 3'd1;
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            PARITY: begin
               if (counter == BIT_LAST) begin
                  counter <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            STOP: begin
               if (counter == BIT_LAST) begin
                  counter          <= '0;
                  RX_data_out      <= shift;
                  RX_data_valid    <= 1'b1;
                  RX_parity_error  <= (par_bit != ^shift);
                  RX_framing_error <= ~rx_s;
                  RX_active        <= 1'b0;
                  // A low stop bit means a break or stuck line; wait for it to release.
                  state            <= rx_s ? IDLE : WAIT_HIGH;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            WAIT_HIGH: begin
               counter <= '0;
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               counter   <= '0;
               RX_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx using a 16-cycles-per-bit link.
// A behavioural transmitter drives the frames and queues the results each frame should produce.
// A monitor pops that queue whenever the receiver strobes valid.
module tb_uart_rx;

   localparam int P   = 16;
   localparam int LAT = 8 + 10 * P + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RX_serial_in_bit = 1'b1;
   logic [7:0] RX_data_out;
   logic       RX_data_valid;
   logic       RX_parity_error;
   logic       RX_framing_error;
   logic       RX_active;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         start;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cycle_count = 0;
   int   last_valid_cycle = 0;
   int   prev_valid_cycle = 0;
   logic prev_valid = 1'b0;

   uart_rx #(.BR(10), .CLK_RATE(160)) dut (
      .clk              (clk),
      .reset            (reset),
      .RX_serial_in_bit (RX_serial_in_bit),
      .RX_data_out      (RX_data_out),
      .RX_data_valid    (RX_data_valid),
      .RX_parity_error  (RX_parity_error),
      .RX_framing_error (RX_framing_error),
      .RX_active        (RX_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   // Monitor: every valid strobe is checked against the oldest queued expectation.
   always begin
      exp_t e;
      int   lat;
      @(posedge clk);
      #1;
      if (RX_data_valid) begin
         prev_valid_cycle = last_valid_cycle;
         last_valid_cycle = cycle_count;
         total++;
         if (prev_valid) begin
            bad++;
            $display("[TB] FAIL valid_width: valid high on consecutive cycles at cycle %0d", cycle_count);
         end
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_valid: got data=%h, required no valid", RX_data_out);
         end else begin
            e = sb.pop_front();
            lat = cycle_count - e.start;
            total++;
            if (RX_data_out !== e.data) begin
               bad++;
               $display("[TB] FAIL data: got %h, required %h", RX_data_out, e.data);
            end
            total++;
            if (RX_parity_error !== e.perr) begin
               bad++;
               $display("[TB] FAIL parity_error: got %b, required %b (data %h)", RX_parity_error, e.perr, e.data);
            end
            total++;
            if (RX_framing_error !== e.ferr) begin
               bad++;
               $display("[TB] FAIL framing_error: got %b, required %b (data %h)", RX_framing_error, e.ferr, e.data);
            end
            total++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
               bad++;
               $display("[TB] FAIL latency: got %0d cycles, required %0d+-1 (data %h)", lat, LAT, e.data);
            end
         end
      end
      prev_valid = RX_data_valid;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic hold(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Behavioural transmitter: one full frame, queueing its expected outcome.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit);
      exp_t e;
      e.data  = d;
      e.perr  = (par != ^d);
      e.ferr  = ~stop_bit;
      e.start = cycle_count;
      sb.push_back(e);
      RX_serial_in_bit = 1'b0;
      hold(P);
      for (int i = 0; i < 8; i++) begin
         RX_serial_in_bit = d[i];
         hold(P);
      end
      RX_serial_in_bit = par;
      hold(P);
      RX_serial_in_bit = stop_bit;
      hold(P);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         hold(1);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: %0d frames outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      total++;
      if ({RX_data_out, RX_data_valid, RX_parity_error, RX_framing_error, RX_active} !== 12'h000) begin
         bad++;
         $display("[TB] FAIL %s: got data=%h v=%b pe=%b fe=%b act=%b, required all 0",
                  tag, RX_data_out, RX_data_valid, RX_parity_error, RX_framing_error, RX_active);
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1 check_idle_outputs("reset_async");
      hold(3);
      reset = 1'b0;
      hold(5);
      check_idle_outputs("reset_release");
   endtask

   task automatic test_good_frame();
      send_frame(8'hA5, 1'b0, 1'b1);
      hold(4);
      drain();
   endtask

   task automatic test_parity_error();
      send_frame(8'h01, 1'b0, 1'b1);
      hold(4);
      drain();
   endtask

   task automatic test_framing_error();
      send_frame(8'h3C, ^8'h3C, 1'b0);
      hold(40 - P);
      total++;
      if (RX_active !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stuck_low_active: got %b, required 0", RX_active);
      end
      RX_serial_in_bit = 1'b1;
      hold(20);
      send_frame(8'h5A, ^8'h5A, 1'b1);
      hold(4);
      drain();
   endtask

   task automatic test_glitch();
      logic saw_active = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 0) RX_serial_in_bit = 1'b0;
         if (i == 4) RX_serial_in_bit = 1'b1;
         hold(1);
         if (RX_active) saw_active = 1'b1;
      end
      total++;
      if (saw_active !== 1'b1) begin
         bad++;
         $display("[TB] FAIL glitch_active_pulse: got %b, required 1", saw_active);
      end
      total++;
      if (RX_active !== 1'b0) begin
         bad++;
         $display("[TB] FAIL glitch_active_drop: got %b, required 0", RX_active);
      end
      total++;
      if ({RX_data_out, RX_parity_error, RX_framing_error} !== {8'h5A, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL glitch_hold: got data=%h pe=%b fe=%b, required 5a 0 0",
                  RX_data_out, RX_parity_error, RX_framing_error);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      hold(4);
      drain();
      total++;
      if (last_valid_cycle - prev_valid_cycle != 11 * P) begin
         bad++;
         $display("[TB] FAIL b2b_spacing: got %0d cycles, required %0d",
                  last_valid_cycle - prev_valid_cycle, 11 * P);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d = 8'hC3;
      RX_serial_in_bit = 1'b0;
      hold(P);
      for (int i = 0; i < 4; i++) begin
         RX_serial_in_bit = d[i];
         hold(P);
      end
      RX_serial_in_bit = d[4];
      hold(P / 2);
      total++;
      if (RX_active !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midframe_active: got %b, required 1", RX_active);
      end
      #2 reset = 1'b1;
      #1 check_idle_outputs("reset_midframe");
      RX_serial_in_bit = 1'b1;
      hold(3);
      reset = 1'b0;
      hold(P * 8);
      check_idle_outputs("reset_midframe_quiet");
      send_frame(8'h81, ^8'h81, 1'b1);
      hold(4);
      drain();
   endtask

   task automatic test_loopback();
      for (int b = 0; b < 256; b++) begin
         send_frame(8'(b), ^(8'(b)), 1'b1);
         hold($urandom_range(0, 3));
      end
      hold(4);
      drain();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_framing_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_loopback();
      hold(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
